// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg -- ID/EX pipeline register with load-use hazard detection.
//
// Captures the decoded instruction (PC, operands, immediate, register
// indices, funct3 and control fields) on each rising clk edge and presents
// it to the execute stage.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   valid_i             decode stage holds a real instruction
//   pc_i, rs1_data_i, rs2_data_i, imm_i     XLEN datapath fields
//   rs1_addr_i, rs2_addr_i, rd_addr_i       5-bit register indices
//   use_rs1_i, use_rs2_i                    instruction reads rs1 / rs2
//   funct3_i                                 branch compare / load-store size
//   pc_sel_i, op1sel_i, op2sel_i, wb_sel_i, pc4_sel_i, mem_wr_i, cpr_en_i,
//   rf_en_i, alu_fun_i                       control decoder outputs
//   stall_i             downstream cannot accept, hold this stage
//   flush_i             EX redirect, kill the incoming instruction
//   *_o                 registered copies of every field above
//   stall_o             combinational load-use request to hold PC and IF/ID
//
// Edge priority: flush_i > stall_i > load-use bubble > normal load.
// A bubble clears valid and every side-effecting control field; data,
// address, funct3 and operand-select fields keep their previous values.
module id_ex_pipe_reg #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            use_rs1_i,
    input  logic            use_rs2_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      pc_sel_i,
    input  logic            op1sel_i,
    input  logic [1:0]      op2sel_i,
    input  logic [1:0]      wb_sel_i,
    input  logic            pc4_sel_i,
    input  logic            mem_wr_i,
    input  logic            cpr_en_i,
    input  logic            rf_en_i,
    input  logic [5:0]      alu_fun_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic [XLEN-1:0] imm_o,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    output logic [4:0]      rd_addr_o,
    output logic [2:0]      funct3_o,
    output logic [1:0]      pc_sel_o,
    output logic            op1sel_o,
    output logic [1:0]      op2sel_o,
    output logic [1:0]      wb_sel_o,
    output logic            pc4_sel_o,
    output logic            mem_wr_o,
    output logic            cpr_en_o,
    output logic            rf_en_o,
    output logic [5:0]      alu_fun_o,
    output logic            stall_o
);

    // Datapath and address registers (hold across bubbles).
    logic [XLEN-1:0] pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
    logic [4:0]      rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd_addr_q, rd_addr_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            op1sel_q, op1sel_d;
    logic [1:0]      op2sel_q, op2sel_d;
    // Side-effecting control registers (cleared by a bubble).
    logic            valid_q, valid_d;
    logic [1:0]      pc_sel_q, pc_sel_d, wb_sel_q, wb_sel_d;
    logic            pc4_sel_q, pc4_sel_d, mem_wr_q, mem_wr_d, cpr_en_q, cpr_en_d, rf_en_q, rf_en_d;
    logic [5:0]      alu_fun_q, alu_fun_d;

    logic load_in_ex_s;
    logic hazard_s;
    logic load_s;
    logic bubble_s;

    // A load sits in EX when it writes the register file from memory (wb_sel 00)
    // to a real destination; x0 is never a hazard.
    assign load_in_ex_s = valid_q & rf_en_q & (wb_sel_q == 2'b00) & (rd_addr_q != 5'd0);
    assign hazard_s     = load_in_ex_s & valid_i & ~flush_i &
                          ((use_rs1_i & (rs1_addr_i == rd_addr_q)) |
                           (use_rs2_i & (rs2_addr_i == rd_addr_q)));
    // Gate with rst_n so the request is quiet while reset is held.
    assign stall_o      = hazard_s & rst_n;

    // Select this edge's action: bubble, hold or load.
    always_comb begin
        if (flush_i) begin
            bubble_s = 1'b1;
            load_s   = 1'b0;
        end else if (stall_i) begin
            bubble_s = 1'b0;
            load_s   = 1'b0;
        end else if (hazard_s || !valid_i) begin
            bubble_s = 1'b1;
            load_s   = 1'b0;
        end else begin
            bubble_s = 1'b0;
            load_s   = 1'b1;
        end
    end

    // Next-state for datapath/address fields: load or hold.
    always_comb begin
        if (load_s) begin
            pc_d       = pc_i;
            rs1_data_d = rs1_data_i;
            rs2_data_d = rs2_data_i;
            imm_d      = imm_i;
            rs1_addr_d = rs1_addr_i;
            rs2_addr_d = rs2_addr_i;
            rd_addr_d  = rd_addr_i;
            funct3_d   = funct3_i;
            op1sel_d   = op1sel_i;
            op2sel_d   = op2sel_i;
        end else begin
            pc_d       = pc_q;
            rs1_data_d = rs1_data_q;
            rs2_data_d = rs2_data_q;
            imm_d      = imm_q;
            rs1_addr_d = rs1_addr_q;
            rs2_addr_d = rs2_addr_q;
            rd_addr_d  = rd_addr_q;
            funct3_d   = funct3_q;
            op1sel_d   = op1sel_q;
            op2sel_d   = op2sel_q;
        end
    end

    // Next-state for control fields: load, clear on bubble, or hold.
    always_comb begin
        if (load_s) begin
            valid_d   = 1'b1;
            pc_sel_d  = pc_sel_i;
            wb_sel_d  = wb_sel_i;
            pc4_sel_d = pc4_sel_i;
            mem_wr_d  = mem_wr_i;
            cpr_en_d  = cpr_en_i;
            rf_en_d   = rf_en_i;
            alu_fun_d = alu_fun_i;
        end else if (bubble_s) begin
            valid_d   = 1'b0;
            pc_sel_d  = 2'b00;
            wb_sel_d  = 2'b00;
            pc4_sel_d = 1'b0;
            mem_wr_d  = 1'b0;
            cpr_en_d  = 1'b0;
            rf_en_d   = 1'b0;
            alu_fun_d = 6'd0;
        end else begin
            valid_d   = valid_q;
            pc_sel_d  = pc_sel_q;
            wb_sel_d  = wb_sel_q;
            pc4_sel_d = pc4_sel_q;
            mem_wr_d  = mem_wr_q;
            cpr_en_d  = cpr_en_q;
            rf_en_d   = rf_en_q;
            alu_fun_d = alu_fun_q;
        end
    end

    // Pipeline state register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_addr_q <= 5'd0;
            rs2_addr_q <= 5'd0;
            rd_addr_q  <= 5'd0;
            funct3_q   <= 3'd0;
            op1sel_q   <= 1'b0;
            op2sel_q   <= 2'b00;
            valid_q    <= 1'b0;
            pc_sel_q   <= 2'b00;
            wb_sel_q   <= 2'b00;
            pc4_sel_q  <= 1'b0;
            mem_wr_q   <= 1'b0;
            cpr_en_q   <= 1'b0;
            rf_en_q    <= 1'b0;
            alu_fun_q  <= 6'd0;
        end else begin
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rd_addr_q  <= rd_addr_d;
            funct3_q   <= funct3_d;
            op1sel_q   <= op1sel_d;
            op2sel_q   <= op2sel_d;
            valid_q    <= valid_d;
            pc_sel_q   <= pc_sel_d;
            wb_sel_q   <= wb_sel_d;
            pc4_sel_q  <= pc4_sel_d;
            mem_wr_q   <= mem_wr_d;
            cpr_en_q   <= cpr_en_d;
            rf_en_q    <= rf_en_d;
            alu_fun_q  <= alu_fun_d;
        end
    end

    assign valid_o    = valid_q;
    assign pc_o       = pc_q;
    assign rs1_data_o = rs1_data_q;
    assign rs2_data_o = rs2_data_q;
    assign imm_o      = imm_q;
    assign rs1_addr_o = rs1_addr_q;
    assign rs2_addr_o = rs2_addr_q;
    assign rd_addr_o  = rd_addr_q;
    assign funct3_o   = funct3_q;
    assign pc_sel_o   = pc_sel_q;
    assign op1sel_o   = op1sel_q;
    assign op2sel_o   = op2sel_q;
    assign wb_sel_o   = wb_sel_q;
    assign pc4_sel_o  = pc4_sel_q;
    assign mem_wr_o   = mem_wr_q;
    assign cpr_en_o   = cpr_en_q;
    assign rf_en_o    = rf_en_q;
    assign alu_fun_o  = alu_fun_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg -- directed bench for id_ex_pipe_reg with a scoreboard of
// expected register contents (pushed when an edge is set up, popped after it).
module tb_id_ex_pipe_reg;
    localparam int XLEN = 32;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc, rs1d, rs2d, imm;
        logic [4:0]      rs1a, rs2a, rda;
        logic [2:0]      f3;
        logic [1:0]      pcsel;
        logic            op1;
        logic [1:0]      op2, wb;
        logic            pc4, memwr, cpr, rfen;
        logic [5:0]      alu;
    } st_t;

    logic clk = 1'b0;
    logic rst_n;
    logic valid_i, use_rs1_i, use_rs2_i, op1sel_i, pc4_sel_i, mem_wr_i, cpr_en_i, rf_en_i, stall_i, flush_i;
    logic [XLEN-1:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
    logic [4:0] rs1_addr_i, rs2_addr_i, rd_addr_i;
    logic [2:0] funct3_i;
    logic [1:0] pc_sel_i, op2sel_i, wb_sel_i;
    logic [5:0] alu_fun_i;
    logic valid_o, op1sel_o, pc4_sel_o, mem_wr_o, cpr_en_o, rf_en_o, stall_o;
    logic [XLEN-1:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
    logic [4:0] rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic [2:0] funct3_o;
    logic [1:0] pc_sel_o, op2sel_o, wb_sel_o;
    logic [5:0] alu_fun_o;

    st_t model, exp_s, got_s;
    st_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    logic exp_stall;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .pc_i(pc_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
        .use_rs1_i(use_rs1_i), .use_rs2_i(use_rs2_i), .funct3_i(funct3_i),
        .pc_sel_i(pc_sel_i), .op1sel_i(op1sel_i), .op2sel_i(op2sel_i), .wb_sel_i(wb_sel_i),
        .pc4_sel_i(pc4_sel_i), .mem_wr_i(mem_wr_i), .cpr_en_i(cpr_en_i), .rf_en_i(rf_en_i),
        .alu_fun_i(alu_fun_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_o(valid_o), .pc_o(pc_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
        .imm_o(imm_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
        .funct3_o(funct3_o), .pc_sel_o(pc_sel_o), .op1sel_o(op1sel_o), .op2sel_o(op2sel_o),
        .wb_sel_o(wb_sel_o), .pc4_sel_o(pc4_sel_o), .mem_wr_o(mem_wr_o), .cpr_en_o(cpr_en_o),
        .rf_en_o(rf_en_o), .alu_fun_o(alu_fun_o), .stall_o(stall_o)
    );

    assign got_s = {valid_o, pc_o, rs1_data_o, rs2_data_o, imm_o, rs1_addr_o, rs2_addr_o,
                    rd_addr_o, funct3_o, pc_sel_o, op1sel_o, op2sel_o, wb_sel_o, pc4_sel_o,
                    mem_wr_o, cpr_en_o, rf_en_o, alu_fun_o};

    function automatic st_t bubble(st_t m);
        st_t b = m;
        b.valid = 1'b0; b.rfen = 1'b0; b.memwr = 1'b0; b.cpr = 1'b0;
        b.pc4 = 1'b0; b.pcsel = 2'b00; b.wb = 2'b00; b.alu = 6'd0;
        return b;
    endfunction

    function automatic st_t capture();
        st_t c;
        c = {1'b1, pc_i, rs1_data_i, rs2_data_i, imm_i, rs1_addr_i, rs2_addr_i, rd_addr_i,
             funct3_i, pc_sel_i, op1sel_i, op2sel_i, wb_sel_i, pc4_sel_i, mem_wr_i,
             cpr_en_i, rf_en_i, alu_fun_i};
        return c;
    endfunction

    function automatic logic hazard(st_t m);
        logic lie;
        lie = m.valid && m.rfen && (m.wb == 2'b00) && (m.rda != 5'd0);
        return lie && valid_i && !flush_i &&
               ((use_rs1_i && (rs1_addr_i == m.rda)) || (use_rs2_i && (rs2_addr_i == m.rda)));
    endfunction

    task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Set decode inputs; remaining fields get random values.
    task automatic set_in(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                          input logic [4:0] d, input logic u1, input logic u2,
                          input logic rf, input logic [1:0] wb, input logic mw);
        valid_i = v; rs1_addr_i = a1; rs2_addr_i = a2; rd_addr_i = d;
        use_rs1_i = u1; use_rs2_i = u2; rf_en_i = rf; wb_sel_i = wb; mem_wr_i = mw;
        pc_i = $urandom; rs1_data_i = $urandom; rs2_data_i = $urandom; imm_i = $urandom;
        funct3_i = 3'($urandom); pc_sel_i = 2'($urandom); op1sel_i = 1'($urandom);
        op2sel_i = 2'($urandom); pc4_sel_i = 1'($urandom); cpr_en_i = 1'($urandom);
        alu_fun_i = 6'($urandom);
    endtask

    // Called at a falling edge with inputs set: checks stall_o, predicts the
    // edge, then compares the registers after the rising edge.
    task automatic step();
        #1;
        exp_stall = hazard(model);
        vectors++;
        assert (stall_o === exp_stall) else begin
            miscompares++;
            $error("FAIL stall_o observed=%b expected=%b", stall_o, exp_stall);
        end
        if (flush_i)                    model = bubble(model);
        else if (stall_i)               model = model;
        else if (exp_stall || !valid_i) model = bubble(model);
        else                            model = capture();
        sb.push_back(model);
        @(posedge clk);
        #1;
        exp_s = sb.pop_front();
        vectors++;
        assert (got_s === exp_s) else begin
            miscompares++;
            $error("FAIL regs observed=%h expected=%h", got_s, exp_s);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        set_in(1'b1, 5'd1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        model = '0;
        #1;
        chk("reset_regs", XLEN'(got_s == '0), XLEN'(1));
        chk("reset_stall", XLEN'(stall_o), XLEN'(0));
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // ADD x3,x1,x2
        set_in(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0);
        alu_fun_i = 6'd0;
        step();
        chk("add_valid", XLEN'(valid_o), XLEN'(1));
        chk("add_rd", XLEN'(rd_addr_o), XLEN'(3));

        // LW x5 then ADD x6,x5,x1: one bubble then capture
        set_in(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
        step();
        set_in(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0);
        #1 chk("lu_stall_hi", XLEN'(stall_o), XLEN'(1));
        step();
        chk("lu_bubble", XLEN'(valid_o), XLEN'(0));
        step();
        chk("lu_capture_rd", XLEN'(rd_addr_o), XLEN'(6));

        // LW x0, then decode reads x0: no hazard
        set_in(1'b1, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
        step();
        set_in(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0);
        #1 chk("x0_no_stall", XLEN'(stall_o), XLEN'(0));
        step();
        chk("x0_no_bubble", XLEN'(valid_o), XLEN'(1));

        // stall_i for 3 cycles with changing inputs, then flush during stall
        set_in(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1);
        step();
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 5'(i + 10), 5'(i + 11), 5'(i + 12), 1'b1, 1'b1, 1'b1, 2'(i), 1'b1);
            step();
        end
        flush_i = 1'b1;
        set_in(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1);
        step();
        chk("flush_stall_valid", XLEN'(valid_o), XLEN'(0));
        chk("flush_stall_memwr", XLEN'(mem_wr_o), XLEN'(0));
        chk("flush_stall_rfen", XLEN'(rf_en_o), XLEN'(0));
        stall_i = 1'b0; flush_i = 1'b0;

        // load-use hazard while stall_i held: hold, then one bubble
        set_in(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        step();
        set_in(1'b1, 5'd3, 5'd8, 5'd9, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0);
        stall_i = 1'b1;
        step();
        step();
        stall_i = 1'b0;
        #1 chk("lu_held_stall", XLEN'(stall_o), XLEN'(1));
        step();
        step();

        // SW with flush
        set_in(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
        flush_i = 1'b1;
        step();
        chk("sw_flush_memwr", XLEN'(mem_wr_o), XLEN'(0));
        flush_i = 1'b0;

        // valid_i=0 loads a bubble
        set_in(1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1);
        step();

        // mixed traffic over a small register range to provoke hazards
        for (int i = 0; i < 40; i++) begin
            set_in(1'($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
                   2'($urandom_range(0, 1)), 1'($urandom));
            stall_i = ($urandom_range(0, 5) == 0);
            flush_i = ($urandom_range(0, 7) == 0);
            step();
        end
        stall_i = 1'b0; flush_i = 1'b0;

        // asynchronous reset between edges with a valid instruction held
        set_in(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_regs", XLEN'(got_s == '0), XLEN'(1));
        chk("async_rst_stall", XLEN'(stall_o), XLEN'(0));
        model = '0;
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/id_ex_pipe_reg.md
ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 SHALL have parameter XLEN, default 32, the datapath width of PC, operand and immediate fields.
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port valid_i, input, 1, the decode stage holds a real instruction.
REQ-005 SHALL have ports pc_i, rs1_data_i, rs2_data_i, imm_i, each input, XLEN, the decode-stage PC, register-file reads and sign-extended immediate.
REQ-006 SHALL have ports rs1_addr_i, rs2_addr_i, rd_addr_i, each input, 5, the decode-stage register indices.
REQ-007 SHALL have ports use_rs1_i, use_rs2_i, each input, 1, the instruction reads rs1/rs2.
REQ-008 SHALL have port funct3_i, input, 3, passed to EX/MEM for branch compare and load/store size.
REQ-009 SHALL have control inputs pc_sel_i[1:0], op1sel_i, op2sel_i[1:0], wb_sel_i[1:0], pc4_sel_i, mem_wr_i, cpr_en_i, rf_en_i, alu_fun_i[5:0], driven by the control decoder.
REQ-010 SHALL have port stall_i, input, 1, the downstream stage cannot accept; hold this stage.
REQ-011 SHALL have port flush_i, input, 1, the EX-stage redirect (taken branch/jump); kill the incoming instruction.
REQ-012 SHALL have registered outputs valid_o, pc_o, rs1_data_o, rs2_data_o, imm_o, rs1_addr_o, rs2_addr_o, rd_addr_o, funct3_o and every control field with suffix _o, each the same width as its input.
REQ-013 SHALL have port stall_o, output, 1, combinational load-use hazard request to hold PC and IF/ID.

Function
REQ-014 Per-edge priority SHALL be flush_i > stall_i > load-use bubble > normal load.
REQ-015 flush_i=1 SHALL load a bubble, even when stall_i=1.
REQ-016 stall_i=1 with flush_i=0 SHALL hold every register unchanged.
REQ-017 Bubble SHALL set valid_o=0, rf_en_o=0, mem_wr_o=0, cpr_en_o=0, pc4_sel_o=0, pc_sel_o=00, wb_sel_o=00, alu_fun_o=0; data and address fields hold their previous values.
REQ-018 Normal load SHALL capture all inputs with one-cycle latency; valid_i=0 SHALL load a bubble.
REQ-019 Load-in-EX SHALL be defined as valid_o=1 and rf_en_o=1 and wb_sel_o=00 and rd_addr_o!=0.
REQ-020 stall_o SHALL be 1 iff load-in-EX and valid_i=1 and flush_i=0 and ((use_rs1_i and rs1_addr_i==rd_addr_o) or (use_rs2_i and rs2_addr_i==rd_addr_o)).
REQ-021 When stall_o=1 and stall_i=0, the edge SHALL load a bubble; the next cycle stall_o SHALL be 0, so exactly one bubble per load-use hazard.
REQ-022 When stall_o=1 and stall_i=1, the stage SHALL hold; stall_o stays asserted until stall_i drops.
REQ-023 rd_addr_o==0 SHALL never raise stall_o, regardless of rs indices.
REQ-024 Control outputs of a valid stage SHALL equal the captured inputs bit-for-bit; no re-encoding.

Reset
REQ-025 rst_n=0 SHALL asynchronously clear every output register to zero (valid_o=0, all controls 0, data/address 0).
REQ-026 While rst_n=0, stall_o SHALL be 0.
REQ-027 After rst_n rises, the first rising edge SHALL perform a normal load per REQ-014.

Verification
REQ-028 ADD x3,x1,x2 (valid_i=1, rf_en_i=1, wb_sel_i=01, alu_fun_i=000000) -> next cycle valid_o=1, rd_addr_o=3, all fields equal inputs.
REQ-029 LW x5 in EX, decode ADD x6,x5,x1 with use_rs1_i=1 -> stall_o=1; next edge valid_o=0; the following cycle stall_o=0 and ADD is captured.
REQ-030 LW x0 in EX, decode reads x0 -> stall_o=0, no bubble.
REQ-031 stall_i=1 for 3 cycles with changing inputs -> outputs constant; flush_i=1 during stall_i=1 -> next cycle valid_o=0, mem_wr_o=0, rf_en_o=0.
REQ-032 SW in decode (mem_wr_i=1) with flush_i=1 -> next cycle mem_wr_o=0, valid_o=0.
REQ-033 rst_n asserted mid-cycle between edges with valid_o=1 -> all outputs 0 immediately, without waiting for clk.
